// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
// Parallel-to-serial front end for a serial "0010" sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock.
// A one-entry holding register lets consecutive words stream with no gap.
// Between words the serial line rests at IDLE_BIT.
module seq_bit_serializer #(
  parameter int   DATA_W    = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_out,
  output logic              ser_active,
  output logic              word_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_full_q, hold_full_d;

  logic                accept;
  logic                last_bit;
  logic [DATA_W-1:0]   shreg_shifted;

  // Ready depends only on registered state and reset, never on s_valid.
  assign s_ready  = rst_n && !hold_full_q;
  assign accept   = s_valid && s_ready;
  assign last_bit = (state_q == SHIFT) && (bitcnt_q == LAST_CNT);

  // Outputs are decoded purely from registers, so they are glitch-free.
  assign ser_active = (state_q == SHIFT);
  assign word_done  = last_bit;
  assign ser_out    = (state_q == SHIFT)
                      ? (MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0])
                      : IDLE_BIT;

  // Move the shift register one place toward whichever end is being sent.
  always_comb begin
    shreg_shifted = shreg_q;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[DATA_W-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[DATA_W-1:1]};
    end
  end

  // Next-state logic: load, shift, hand off the held word, or fall idle.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        // The holding register is bypassed when nothing is shifting.
        if (accept) begin
          shreg_d  = s_data;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          shreg_d  = shreg_shifted;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (accept) begin
            hold_data_d = s_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // s_ready is low here, so no accept can collide with the handoff.
          shreg_d     = hold_data_q;
          hold_full_d = 1'b0;
          bitcnt_d    = '0;
        end else if (accept) begin
          shreg_d  = s_data;
          bitcnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards both the shifting and the held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer
// Directed bench: a table of per-cycle vectors for reset, idle and a
// single MSB-first word, then hand-written sequences for back-to-back
// streaming, last-bit accept, reset with a held word, and LSB-first order.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       ser_out;
  logic       ser_active;
  logic       word_done;

  logic [7:0] l_data;
  logic       l_valid;
  logic       l_ready;
  logic       l_ser_out;
  logic       l_active;
  logic       l_done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       e_ser;
    logic       e_act;
    logic       e_done;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  seq_bit_serializer #(
    .DATA_W   (8),
    .MSB_FIRST(1'b1),
    .IDLE_BIT (1'b1)
  ) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .ser_out   (ser_out),
    .ser_active(ser_active),
    .word_done (word_done)
  );

  seq_bit_serializer #(
    .DATA_W   (8),
    .MSB_FIRST(1'b0),
    .IDLE_BIT (1'b1)
  ) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (l_data),
    .s_valid   (l_valid),
    .s_ready   (l_ready),
    .ser_out   (l_ser_out),
    .ser_active(l_active),
    .word_done (l_done)
  );

  task automatic compare(input string what, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%b want=%b at t=%0t", what, got, want, $time);
    end
  endtask

  // Drive inputs just after the rising edge so they are stable for the next one.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    rst_n   = r;
    s_valid = v;
    s_data  = d;
  endtask

  // Sample outputs on the falling edge, well away from the active edge.
  task automatic checkOutput(input string tag, input logic e_ser, input logic e_act,
                             input logic e_done, input logic e_rdy);
    @(negedge clk);
    compare({tag, "/ser_out"},    ser_out,    e_ser);
    compare({tag, "/ser_active"}, ser_active, e_act);
    compare({tag, "/word_done"},  word_done,  e_done);
    compare({tag, "/s_ready"},    s_ready,    e_rdy);
  endtask

  task automatic runCycle(input string tag, input logic r, input logic v, input logic [7:0] d,
                          input logic e_ser, input logic e_act, input logic e_done,
                          input logic e_rdy);
    applyStimulus(r, v, d);
    checkOutput(tag, e_ser, e_act, e_done, e_rdy);
  endtask

  task automatic addVec(input logic r, input logic v, input logic [7:0] d,
                        input logic e_ser, input logic e_act, input logic e_done,
                        input logic e_rdy);
    vec_t t;
    t.rst_n  = r;
    t.valid  = v;
    t.data   = d;
    t.e_ser  = e_ser;
    t.e_act  = e_act;
    t.e_done = e_done;
    t.e_rdy  = e_rdy;
    vecs.push_back(t);
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] stream;

    // Table: reset row, 10 idle cycles (junk data with valid low), one word 8'h12.
    addVec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) addVec(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    w = 8'h12;
    for (int i = 0; i < 8; i++) addVec(1'b1, 1'b0, 8'hFF, w[7-i], 1'b1, (i == 7), 1'b1);
    addVec(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    l_valid = 1'b0;
    l_data  = 8'h00;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      runCycle($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].valid, vecs[i].data,
               vecs[i].e_ser, vecs[i].e_act, vecs[i].e_done, vecs[i].e_rdy);
    end

    // Back-to-back A5 then 3C, valid held high through the ready-low window.
    $display("[TB] back-to-back A5/3C");
    stream = 16'hA53C;
    runCycle("b2b_acc", 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      runCycle($sformatf("b2b%0d", i), 1'b1, (i <= 7), 8'h3C, stream[15-i], 1'b1,
               (i == 7) || (i == 15), !((i >= 1) && (i <= 7)));
    end
    runCycle("b2b_idle", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Second word offered exactly on the last-bit cycle with the hold empty.
    $display("[TB] last-bit accept 0F/F0");
    stream = 16'h0FF0;
    runCycle("lb_acc", 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      runCycle($sformatf("lb%0d", i), 1'b1, (i == 7), (i == 7) ? 8'hF0 : 8'hAA,
               stream[15-i], 1'b1, (i == 7) || (i == 15), 1'b1);
    end
    runCycle("lb_idle", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset during bit 3 of C3 while 55 sits in the holding register.
    $display("[TB] reset with held word");
    w = 8'hC3;
    runCycle("rst_acc",  1'b1, 1'b1, 8'hC3, 1'b1,  1'b0, 1'b0, 1'b1);
    runCycle("rst_b0",   1'b1, 1'b1, 8'h55, w[7],  1'b1, 1'b0, 1'b1);
    runCycle("rst_b1",   1'b1, 1'b0, 8'h00, w[6],  1'b1, 1'b0, 1'b0);
    runCycle("rst_b2",   1'b1, 1'b0, 8'h00, w[5],  1'b1, 1'b0, 1'b0);
    runCycle("rst_b3",   1'b0, 1'b0, 8'h00, w[4],  1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      runCycle($sformatf("rst_after%0d", i), 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // LSB-first instance: 8'h01 goes out as 1 then seven 0s.
    $display("[TB] LSB-first 01");
    w = 8'h01;
    @(posedge clk);
    #1;
    l_valid = 1'b1;
    l_data  = 8'h01;
    @(negedge clk);
    compare("lsb_acc/ser_out", l_ser_out, 1'b1);
    compare("lsb_acc/s_ready", l_ready,   1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      l_valid = 1'b0;
      l_data  = 8'hFF;
      @(negedge clk);
      compare($sformatf("lsb%0d/ser_out", i),    l_ser_out, w[i]);
      compare($sformatf("lsb%0d/ser_active", i), l_active,  1'b1);
      compare($sformatf("lsb%0d/word_done", i),  l_done,    (i == 7));
    end
    @(posedge clk);
    @(negedge clk);
    compare("lsb_idle/ser_out",    l_ser_out, 1'b1);
    compare("lsb_idle/ser_active", l_active,  1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
